inner_prod_mac: RTL and testbench

Parametrised, sequential signed inner-product unit. It computes the dot product of one matrix row and one matrix column, each packed as N elements of DW bits, using LANES multiply-accumulate lanes per cycle. It sits inside the matrix multiplier datapath and is shared across row/column pairs through a valid/ready handshake. Products and the running sum are kept at full precision; overflow is judged only on the final sum.

---
 rtl/inner_prod_mac.sv | 145 ++++++++++++++
 tb/tb_inner_prod_mac.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inner_prod_mac.sv
// Sequential signed inner product of two packed N-element vectors, LANES MACs per beat.
// Optional saturation of the result is enabled by defining INTPROD_SAT_EN.
module inner_prod_mac #(
  parameter int unsigned DW    = 8,
  parameter int unsigned N     = 5,
  parameter int unsigned LANES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] lin,
  input  logic [N*DW-1:0] col,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   n_out,
  output logic            ovf
);

  localparam int unsigned K  = N / LANES;
  localparam int unsigned AW = 2 * DW + $clog2(N) + 1;
  localparam int unsigned BW = (K > 1) ? $clog2(K) : 1;

  localparam logic [BW-1:0]        LastBeat = BW'(K - 1);
  localparam logic signed [AW-1:0] SumMax   = {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [AW-1:0] SumMin   = {{(AW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  if ((N % LANES) != 0) begin : gen_lanes_chk
    $error("inner_prod_mac: N must be a multiple of LANES");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [N*DW-1:0]      lin_q, lin_d;
  logic [N*DW-1:0]      col_q, col_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [DW-1:0]        n_out_q, n_out_d;
  logic                 ovf_q, ovf_d;

  logic [31:0]          elem_base;
  logic signed [AW-1:0] prod_ext [LANES];
  logic signed [AW-1:0] lane_sum;
  logic signed [AW-1:0] acc_sum;
  logic                 sum_ovf;
  logic [DW-1:0]        sum_res;

  assign elem_base = 32'(beat_q) * LANES;

  // Full-precision product per lane, sign-extended to the accumulator width.
  for (genvar g = 0; g < LANES; g++) begin : gen_lane
    logic signed [DW-1:0]   lane_a;
    logic signed [DW-1:0]   lane_b;
    logic signed [2*DW-1:0] lane_p;

    assign lane_a      = lin_q[(elem_base + g) * DW +: DW];
    assign lane_b      = col_q[(elem_base + g) * DW +: DW];
    assign lane_p      = lane_a * lane_b;
    assign prod_ext[g] = {{(AW - 2 * DW){lane_p[2*DW-1]}}, lane_p};
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_sum = lane_sum + prod_ext[l];
    end
    acc_sum = acc_q + lane_sum;
    sum_ovf = (acc_sum > SumMax) || (acc_sum < SumMin);
  end

`ifdef INTPROD_SAT_EN
  always_comb begin
    sum_res = acc_sum[DW-1:0];
    if (sum_ovf) begin
      sum_res = acc_sum[AW-1] ? {1'b1, {(DW - 1){1'b0}}} : {1'b0, {(DW - 1){1'b1}}};
    end
  end
`else
  assign sum_res = acc_sum[DW-1:0];
`endif

  always_comb begin
    state_d = state_q;
    lin_d   = lin_q;
    col_d   = col_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    n_out_d = n_out_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          lin_d   = lin;
          col_d   = col;
          acc_d   = '0;
          beat_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_sum;
        if (beat_q == LastBeat) begin
          n_out_d = sum_res;
          ovf_d   = sum_ovf;
          state_d = StDone;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lin_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
      n_out_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lin_q   <= lin_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      n_out_q <= n_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign n_out     = n_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_inner_prod_mac.sv
// Directed bench for inner_prod_mac: one instance with LANES=1, one with LANES=5.
// Expected results follow INTPROD_SAT_EN when the bench is built with it.
module tb_inner_prod_mac;

`ifdef INTPROD_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid_a, in_valid_b;
  logic        in_ready_a, in_ready_b;
  logic [39:0] lin, col;
  logic        out_valid_a, out_valid_b;
  logic        out_ready;
  logic [7:0]  n_out_a, n_out_b;
  logic        ovf_a, ovf_b;

  int checks = 0;
  int errors = 0;

  inner_prod_mac #(.DW(8), .N(5), .LANES(1)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .lin       (lin),
    .col       (col),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .n_out     (n_out_a),
    .ovf       (ovf_a)
  );

  inner_prod_mac #(.DW(8), .N(5), .LANES(5)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .lin       (lin),
    .col       (col),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .n_out     (n_out_b),
    .ovf       (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] pk(input int e0, input int e1, input int e2, input int e3,
                                     input int e4);
    logic [39:0] v;
    v = {8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input bit sel, output int cyc);
    cyc = 0;
    while (!(sel ? out_valid_b : out_valid_a) && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  // Accept one pair, scramble the inputs, then check latency, result and return to idle.
  task automatic run_vec(input string tag, input bit sel, input logic [39:0] l,
                         input logic [39:0] c, input logic [7:0] exp_n, input logic exp_o,
                         input int exp_lat);
    int cyc;
    cyc = 0;
    while (!(sel ? in_ready_b : in_ready_a) && cyc < 20) begin
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    lin = l;
    col = c;
    if (sel) in_valid_b = 1'b1;
    else     in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    lin = ~l;
    col = ~c;
    wait_out(sel, cyc);
    check_eq({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check_eq({tag, "_n"}, 32'(sel ? n_out_b : n_out_a), 32'(exp_n));
    check_eq({tag, "_ovf"}, 32'(sel ? ovf_b : ovf_a), 32'(exp_o));
    tick();
    check_eq({tag, "_rdy"}, 32'(sel ? in_ready_b : in_ready_a), 32'd1);
    check_eq({tag, "_vld_lo"}, 32'(sel ? out_valid_b : out_valid_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [39:0] ones;
    logic [39:0] tens;
    int cyc;
    ones = pk(1, 1, 1, 1, 1);
    tens = pk(10, 10, 10, 10, 10);
    rst = 1'b1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    out_ready = 1'b1;
    lin = '0;
    col = '0;
    tick();
    tick();
    check_eq("rst_rdy", 32'(in_ready_a), 32'd1);
    check_eq("rst_vld", 32'(out_valid_a), 32'd0);
    check_eq("rst_n", 32'(n_out_a), 32'd0);
    check_eq("rst_ovf", 32'(ovf_a), 32'd0);
    check_eq("rst_vld_b", 32'(out_valid_b), 32'd0);
    rst = 1'b0;
    tick();

    run_vec("basic", 1'b0, pk(1, 2, 3, 4, 5), ones, 8'd15, 1'b0, 5);
    run_vec("neg", 1'b0, pk(-1, -2, -3, -4, -5), ones, 8'hF1, 1'b0, 5);
    run_vec("pos_ovf", 1'b0, tens, tens, Sat ? 8'h7F : 8'hF4, 1'b1, 5);
    run_vec("prod_ovf", 1'b0, pk(-128, 0, 0, 0, 0), pk(-128, 0, 0, 0, 0),
            Sat ? 8'h7F : 8'h00, 1'b1, 5);
    run_vec("cancel", 1'b0, pk(100, 100, 0, 0, 0), pk(2, -2, 0, 0, 0), 8'h00, 1'b0, 5);
    run_vec("max", 1'b0, pk(127, 0, 0, 0, 0), ones, 8'h7F, 1'b0, 5);
    run_vec("max_p1", 1'b0, pk(127, 1, 0, 0, 0), ones, Sat ? 8'h7F : 8'h80, 1'b1, 5);
    run_vec("min", 1'b0, pk(-128, 0, 0, 0, 0), ones, 8'h80, 1'b0, 5);
    run_vec("min_m1", 1'b0, pk(-128, -1, 0, 0, 0), ones, Sat ? 8'h80 : 8'h7F, 1'b1, 5);

    // Backpressure: result held, new pair ignored until the consumer accepts.
    out_ready = 1'b0;
    lin = pk(1, 2, 3, 4, 5);
    col = ones;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    wait_out(1'b0, cyc);
    check_eq("bp_lat", 32'(cyc), 32'd5);
    lin = tens;
    col = tens;
    in_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_vld", 32'(out_valid_a), 32'd1);
      check_eq("bp_n", 32'(n_out_a), 32'd15);
      check_eq("bp_ovf", 32'(ovf_a), 32'd0);
      check_eq("bp_rdy", 32'(in_ready_a), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_eq("bp_rel_rdy", 32'(in_ready_a), 32'd1);
    check_eq("bp_rel_vld", 32'(out_valid_a), 32'd0);
    tick();
    in_valid_a = 1'b0;
    wait_out(1'b0, cyc);
    check_eq("bp_new_lat", 32'(cyc), 32'd5);
    check_eq("bp_new_n", 32'(n_out_a), 32'(Sat ? 8'h7F : 8'hF4));
    check_eq("bp_new_ovf", 32'(ovf_a), 32'd1);
    tick();

    // Reset on beat 2 discards the operation.
    lin = pk(1, 2, 3, 4, 5);
    col = ones;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_vld", 32'(out_valid_a), 32'd0);
    check_eq("mrst_n", 32'(n_out_a), 32'd0);
    check_eq("mrst_ovf", 32'(ovf_a), 32'd0);
    check_eq("mrst_rdy", 32'(in_ready_a), 32'd1);
    repeat (6) tick();
    check_eq("mrst_idle_vld", 32'(out_valid_a), 32'd0);
    run_vec("post_rst", 1'b0, pk(1, 2, 3, 4, 5), ones, 8'd15, 1'b0, 5);

    // Reset wins over a simultaneous request.
    lin = tens;
    col = tens;
    rst = 1'b1;
    in_valid_a = 1'b1;
    tick();
    rst = 1'b0;
    in_valid_a = 1'b0;
    check_eq("rst_iv_rdy", 32'(in_ready_a), 32'd1);
    tick();
    check_eq("rst_iv_rdy2", 32'(in_ready_a), 32'd1);

    run_vec("l5_min", 1'b1, pk(-128, -128, -128, -128, -128), ones, 8'h80, 1'b1, 1);
    run_vec("l5_basic", 1'b1, pk(1, 2, 3, 4, 5), ones, 8'd15, 1'b0, 1);
    run_vec("l5_cancel", 1'b1, pk(100, 100, 0, 0, 0), pk(2, -2, 0, 0, 0), 8'h00, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
